lc3_mem_ctrl: RTL

CPU-side initiator for the LC-3 memory bus. It accepts one load/store request at a time from the datapath (MAR/MDR side) and runs the MIO_EN/RW/R handshake against the memory responder. Accesses to the keyboard and display device registers (KBSR/KBDR/DSR/DDR) are served locally and never reach the bus. It sits between the datapath/control FSM and the memory array, and owns the character I/O handshakes.

---
 rtl/lc3_pkg.sv | 27 ++
 rtl/lc3_io_regs.sv | 89 ++++++++
 rtl/lc3_mem_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory controller: device register map,
// controller state encoding and the device-select type used by the I/O block.
package lc3_pkg;

   localparam logic [15:0] DEF_KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] DEF_KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DEF_DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DEF_DDR_ADDR  = 16'hFE06;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUS     = 2'd1;
   localparam logic [1:0] ST_RECOVER = 2'd2;
   localparam logic [1:0] ST_IO      = 2'd3;

   typedef enum logic [2:0] {
      DEV_NONE = 3'd0,
      DEV_KBSR = 3'd1,
      DEV_KBDR = 3'd2,
      DEV_DSR  = 3'd3,
      DEV_DDR  = 3'd4
   } dev_e;

   function automatic logic is_device(input dev_e dev);
      return (dev != DEV_NONE);
   endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// Locally served keyboard/display registers and their address decode.
// The access strobe marks the edge on which a device read/write takes effect.
module lc3_io_regs
   import lc3_pkg::*;
#(
   parameter logic [15:0] KBSR_ADDR = DEF_KBSR_ADDR,
   parameter logic [15:0] KBDR_ADDR = DEF_KBDR_ADDR,
   parameter logic [15:0] DSR_ADDR  = DEF_DSR_ADDR,
   parameter logic [15:0] DDR_ADDR  = DEF_DDR_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        access,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   input  logic        tx_ready,
   output logic        is_dev,
   output logic [15:0] rd_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data
);

   dev_e dev;
   logic kb_full;
   logic [7:0] kb_reg;

   // Address decode onto the device map.
   always_comb begin
      dev = DEV_NONE;
      if (addr == KBSR_ADDR) begin
         dev = DEV_KBSR;
      end else if (addr == KBDR_ADDR) begin
         dev = DEV_KBDR;
      end else if (addr == DSR_ADDR) begin
         dev = DEV_DSR;
      end else if (addr == DDR_ADDR) begin
         dev = DEV_DDR;
      end else begin
         dev = DEV_NONE;
      end
   end

   assign is_dev = is_device(dev);

   // Load data for a device read; stores and DDR reads return zero.
   always_comb begin
      rd_data = 16'h0000;
      if (we) begin
         rd_data = 16'h0000;
      end else begin
         case (dev)
            DEV_KBSR: rd_data = {kb_full, 15'h0000};
            DEV_KBDR: rd_data = {8'h00, kb_reg};
            DEV_DSR:  rd_data = {~tx_valid, 15'h0000};
            default:  rd_data = 16'h0000;
         endcase
      end
   end

   // Keyboard holding register; a new strobe beats a simultaneous KBDR read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kb_full <= 1'b0;
         kb_reg  <= 8'h00;
      end else if (kb_valid) begin
         kb_full <= 1'b1;
         kb_reg  <= kb_data;
      end else if (access && !we && (dev == DEV_KBDR)) begin
         kb_full <= 1'b0;
      end
   end

   // Display register; a DDR write while a character is pending is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else if (access && we && (dev == DEV_DDR) && !tx_valid) begin
         tx_valid <= 1'b1;
         tx_data  <= wdata;
      end else if (tx_valid && tx_ready) begin
         tx_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 CPU-side memory bus initiator: runs the MIO_EN/RW/R handshake for
// ordinary addresses and hands device-register accesses to lc3_io_regs.
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter logic [15:0] KBSR_ADDR = DEF_KBSR_ADDR,
   parameter logic [15:0] KBDR_ADDR = DEF_KBDR_ADDR,
   parameter logic [15:0] DSR_ADDR  = DEF_DSR_ADDR,
   parameter logic [15:0] DDR_ADDR  = DEF_DDR_ADDR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        ready,
   output logic        done,
   output logic [15:0] rdata,
   output logic        MIO_EN,
   output logic        RW,
   output logic [15:0] addr,
   output logic [15:0] data_in,
   input  logic [15:0] data_out,
   input  logic        R,
   input  logic        kb_valid,
   input  logic [7:0]  kb_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready
);

   logic [1:0]  state;
   logic        is_dev;
   logic        io_access;
   logic [15:0] io_rdata;

   // Device accesses take effect on the accepting edge so done follows it directly.
   assign io_access = (state == ST_IDLE) && !R && req && is_dev;

   lc3_io_regs #(
      .KBSR_ADDR (KBSR_ADDR),
      .KBDR_ADDR (KBDR_ADDR),
      .DSR_ADDR  (DSR_ADDR),
      .DDR_ADDR  (DDR_ADDR)
   ) u_io_regs (
      .clk      (clk),
      .rst      (rst),
      .access   (io_access),
      .we       (we),
      .addr     (req_addr),
      .wdata    (req_wdata[7:0]),
      .kb_valid (kb_valid),
      .kb_data  (kb_data),
      .tx_ready (tx_ready),
      .is_dev   (is_dev),
      .rd_data  (io_rdata),
      .tx_valid (tx_valid),
      .tx_data  (tx_data)
   );

   // Access FSM and registered bus drivers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         rdata   <= 16'h0000;
         MIO_EN  <= 1'b0;
         RW      <= 1'b0;
         addr    <= 16'h0000;
         data_in <= 16'h0000;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A stale R (e.g. after a reset mid-access) must clear first.
               if (R) begin
                  state <= ST_RECOVER;
                  ready <= 1'b0;
               end else if (req) begin
                  ready <= 1'b0;
                  if (is_dev) begin
                     state <= ST_IO;
                     done  <= 1'b1;
                     if (!we) begin
                        rdata <= io_rdata;
                     end
                  end else begin
                     state   <= ST_BUS;
                     MIO_EN  <= 1'b1;
                     RW      <= we;
                     addr    <= req_addr;
                     data_in <= req_wdata;
                  end
               end
            end
            ST_BUS: begin
               if (R) begin
                  if (!RW) begin
                     rdata <= data_out;
                  end
                  done   <= 1'b1;
                  MIO_EN <= 1'b0;
                  RW     <= 1'b0;
                  state  <= ST_RECOVER;
               end
            end
            ST_RECOVER: begin
               if (!R) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end
            end
            ST_IO: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state  <= ST_IDLE;
               ready  <= 1'b1;
               MIO_EN <= 1'b0;
               RW     <= 1'b0;
            end
         endcase
      end
   end

endmodule
